bit_serial_substractor: RTL



---
 rtl/sub_pkg.sv | 14 +
 rtl/demux_full_substractor_cell.sv | 32 +++
 rtl/bit_serial_substractor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared encodings for the bit-serial subtractor: FSM states and the demux minterm
// tables that define the full-subtractor cell.
package sub_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam int NUM_MT = 4;

  // Select is {a, b, bin}; difference and borrow are the OR of these demux lines.
  localparam logic [2:0] DIFF_MT [NUM_MT] = '{3'd1, 3'd2, 3'd4, 3'd7};
  localparam logic [2:0] BORR_MT [NUM_MT] = '{3'd1, 3'd2, 3'd3, 3'd7};

endpackage

// File: rtl/demux_full_substractor_cell.sv
// Single-bit full subtractor built from a 1x8 demultiplexer of constant 1, with the
// outputs formed by ORing the demux lines listed in the package minterm tables.
module demux_full_substractor_cell
  import sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic [2:0] sel;
  logic [7:0] line;

  assign sel = {a, b, bin};

  always_comb begin
    line      = '0;
    line[sel] = 1'b1;
  end

  always_comb begin
    d  = 1'b0;
    bo = 1'b0;
    for (int i = 0; i < NUM_MT; i++) begin
      d  = d  | line[DIFF_MT[i]];
      bo = bo | line[BORR_MT[i]];
    end
  end

endmodule

// File: rtl/bit_serial_substractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single demux-based
// full-subtractor cell, with start/done handshake and signed-overflow reporting.
module bit_serial_substractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("bit_serial_substractor: WIDTH must be at least 2");
  end

  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic cell_d;
  logic cell_bo;

  demux_full_substractor_cell u_cell (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        r_sh_d   = {cell_d, r_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = cell_bo;
        if (cnt_q == LAST) begin
          // borrow_q here is the borrow into the MSB; XOR with borrow out flags signed overflow
          diff_d  = r_sh_d;
          bout_d  = cell_bo;
          ovf_d   = borrow_q ^ cell_bo;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule
